// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared sizes and slot/tag typedefs for the instruction queue
package mips_core_pkg;

    localparam int IQ_DEPTH   = 32;
    localparam int PREG_COUNT = 64;
    localparam int AL_IDX_W   = 5;
    localparam int IQ_IDX_W   = $clog2(IQ_DEPTH);
    localparam int PREG_W     = $clog2(PREG_COUNT);
    // occupancy must reach IQ_DEPTH itself, hence the +1
    localparam int OCC_W      = $clog2(IQ_DEPTH + 1);

    typedef logic [IQ_IDX_W-1:0] IqSlot;
    typedef logic [PREG_W-1:0]   PhysReg;
    typedef logic [AL_IDX_W-1:0] AlIdx;

endpackage

// File: rtl/iq_age_matrix.sv
// rtl/iq_age_matrix.sv - relative-age tracking and oldest-requester select
// Ports: clk, rst (async high); alloc_en/alloc_idx mark a new youngest slot;
// valid_vec is the pre-edge valid set; free_vec lists slots leaving at the edge;
// flush clears everything; req is the request vector, grant its one-hot oldest.
module iq_age_matrix #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_en,
    input  logic [$clog2(N)-1:0] alloc_idx,
    input  logic [N-1:0]         valid_vec,
    input  logic [N-1:0]         free_vec,
    input  logic                 flush,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant
);

    localparam int IDX_W = $clog2(N);

    // older_q[i][j] = 1 means slot j is older than slot i
    logic [N-1:0][N-1:0] older_q;
    logic [N-1:0][N-1:0] older_d;

    always_comb begin
        older_d = older_q;
        grant   = '0;
        for (int i = 0; i < N; i++) begin
            // freeing slot j clears column j in every row
            older_d[i] = older_q[i] & ~free_vec;
            // a fresh slot is younger than everything that stays valid
            if (alloc_en && alloc_idx == IDX_W'(i)) begin
                older_d[i] = valid_vec & ~free_vec;
            end
            if (flush) begin
                older_d[i] = '0;
            end
            grant[i] = req[i] & ~(|(older_q[i] & req));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end

endmodule

// File: rtl/iq_issue_scheduler.sv
// rtl/iq_issue_scheduler.sv - slot allocation, operand wakeup and oldest-ready issue select
// Ports: dispatch_* (valid/ready handshake, source tags, readiness, al index),
// alloc_slot (payload write index), wakeup_valid/wakeup_preg (writeback tag),
// issue_valid/issue_ready/issue_slot/issue_al_idx (issue handshake), flush, occupancy.
module iq_issue_scheduler
    import mips_core_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                dispatch_valid,
    output logic                dispatch_ready,
    input  logic                dispatch_uses_rs,
    input  logic                dispatch_uses_rt,
    input  logic [PREG_W-1:0]   dispatch_rs_preg,
    input  logic [PREG_W-1:0]   dispatch_rt_preg,
    input  logic                dispatch_rs_rdy,
    input  logic                dispatch_rt_rdy,
    input  logic [AL_IDX_W-1:0] dispatch_al_idx,
    output logic [IQ_IDX_W-1:0] alloc_slot,
    input  logic                wakeup_valid,
    input  logic [PREG_W-1:0]   wakeup_preg,
    output logic                issue_valid,
    input  logic                issue_ready,
    output logic [IQ_IDX_W-1:0] issue_slot,
    output logic [AL_IDX_W-1:0] issue_al_idx,
    input  logic                flush,
    output logic [OCC_W-1:0]    occupancy
);

    logic [IQ_DEPTH-1:0] valid_q, valid_d;
    logic [IQ_DEPTH-1:0] rs_rdy_q, rs_rdy_d;
    logic [IQ_DEPTH-1:0] rt_rdy_q, rt_rdy_d;
    PhysReg              rs_preg_q [IQ_DEPTH];
    PhysReg              rs_preg_d [IQ_DEPTH];
    PhysReg              rt_preg_q [IQ_DEPTH];
    PhysReg              rt_preg_d [IQ_DEPTH];
    AlIdx                al_idx_q  [IQ_DEPTH];
    AlIdx                al_idx_d  [IQ_DEPTH];
    logic                lock_q, lock_d;
    IqSlot               lock_slot_q, lock_slot_d;
    logic [OCC_W-1:0]    occupancy_q, occupancy_d;

    IqSlot               alloc_idx;
    IqSlot               grant_idx;
    logic [IQ_DEPTH-1:0] req, grant, free_vec;
    logic                disp_fire, issue_fire;

    // lowest-index free slot
    always_comb begin
        alloc_idx = '0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_idx = IqSlot'(i);
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (grant[i]) begin
                grant_idx = IqSlot'(i);
            end
        end
    end

    assign req            = valid_q & rs_rdy_q & rt_rdy_q;
    assign dispatch_ready = ~rst & ~flush & (occupancy_q != OCC_W'(IQ_DEPTH));
    assign alloc_slot     = alloc_idx;
    // the lock keeps a stalled presentation stable even if an older slot wakes
    assign issue_valid    = ~flush & (lock_q | (|req));
    assign issue_slot     = lock_q ? lock_slot_q : grant_idx;
    assign issue_al_idx   = al_idx_q[issue_slot];
    assign occupancy      = occupancy_q;
    assign disp_fire      = dispatch_valid & dispatch_ready;
    assign issue_fire     = issue_valid & issue_ready;

    always_comb begin
        free_vec = '0;
        if (issue_fire) begin
            free_vec[issue_slot] = 1'b1;
        end
    end

    iq_age_matrix #(.N(IQ_DEPTH)) u_age (
        .clk       (clk),
        .rst       (rst),
        .alloc_en  (disp_fire),
        .alloc_idx (alloc_idx),
        .valid_vec (valid_q),
        .free_vec  (free_vec),
        .flush     (flush),
        .req       (req),
        .grant     (grant)
    );

    always_comb begin
        valid_d   = valid_q;
        rs_rdy_d  = rs_rdy_q;
        rt_rdy_d  = rt_rdy_q;
        rs_preg_d = rs_preg_q;
        rt_preg_d = rt_preg_q;
        al_idx_d  = al_idx_q;

        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (valid_q[i] && wakeup_valid) begin
                if (rs_preg_q[i] == wakeup_preg) rs_rdy_d[i] = 1'b1;
                if (rt_preg_q[i] == wakeup_preg) rt_rdy_d[i] = 1'b1;
            end
        end

        if (issue_fire) begin
            valid_d[issue_slot] = 1'b0;
        end

        // unused operands are recorded as ready; a same-cycle wakeup bypasses in
        if (disp_fire) begin
            valid_d[alloc_idx]   = 1'b1;
            rs_rdy_d[alloc_idx]  = ~dispatch_uses_rs | dispatch_rs_rdy |
                                   (wakeup_valid && wakeup_preg == dispatch_rs_preg);
            rt_rdy_d[alloc_idx]  = ~dispatch_uses_rt | dispatch_rt_rdy |
                                   (wakeup_valid && wakeup_preg == dispatch_rt_preg);
            rs_preg_d[alloc_idx] = dispatch_rs_preg;
            rt_preg_d[alloc_idx] = dispatch_rt_preg;
            al_idx_d[alloc_idx]  = dispatch_al_idx;
        end

        if (flush) begin
            valid_d = '0;
        end

        // issue_valid is already low during flush, so the lock clears then too
        lock_d      = issue_valid & ~issue_ready;
        lock_slot_d = issue_slot;

        occupancy_d = flush ? '0
                            : occupancy_q + OCC_W'(disp_fire) - OCC_W'(issue_fire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            rs_rdy_q    <= '0;
            rt_rdy_q    <= '0;
            lock_q      <= 1'b0;
            lock_slot_q <= '0;
            occupancy_q <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                rs_preg_q[i] <= '0;
                rt_preg_q[i] <= '0;
                al_idx_q[i]  <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            rs_rdy_q    <= rs_rdy_d;
            rt_rdy_q    <= rt_rdy_d;
            lock_q      <= lock_d;
            lock_slot_q <= lock_slot_d;
            occupancy_q <= occupancy_d;
            rs_preg_q   <= rs_preg_d;
            rt_preg_q   <= rt_preg_d;
            al_idx_q    <= al_idx_d;
        end
    end

endmodule

// File: tb/tb_iq_issue_scheduler.sv
// tb/tb_iq_issue_scheduler.sv - scoreboard bench for iq_issue_scheduler
module tb_iq_issue_scheduler;
    import mips_core_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dispatch_valid = 1'b0;
    logic       dispatch_ready;
    logic       dispatch_uses_rs = 1'b0, dispatch_uses_rt = 1'b0;
    logic [5:0] dispatch_rs_preg = '0, dispatch_rt_preg = '0;
    logic       dispatch_rs_rdy = 1'b0, dispatch_rt_rdy = 1'b0;
    logic [4:0] dispatch_al_idx = '0;
    logic [4:0] alloc_slot;
    logic       wakeup_valid = 1'b0;
    logic [5:0] wakeup_preg = '0;
    logic       issue_valid;
    logic       issue_ready = 1'b0;
    logic [4:0] issue_slot;
    logic [4:0] issue_al_idx;
    logic       flush = 1'b0;
    logic [5:0] occupancy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [4:0] slot;
        logic [4:0] al;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    iq_issue_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .dispatch_valid   (dispatch_valid),
        .dispatch_ready   (dispatch_ready),
        .dispatch_uses_rs (dispatch_uses_rs),
        .dispatch_uses_rt (dispatch_uses_rt),
        .dispatch_rs_preg (dispatch_rs_preg),
        .dispatch_rt_preg (dispatch_rt_preg),
        .dispatch_rs_rdy  (dispatch_rs_rdy),
        .dispatch_rt_rdy  (dispatch_rt_rdy),
        .dispatch_al_idx  (dispatch_al_idx),
        .alloc_slot       (alloc_slot),
        .wakeup_valid     (wakeup_valid),
        .wakeup_preg      (wakeup_preg),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_slot       (issue_slot),
        .issue_al_idx     (issue_al_idx),
        .flush            (flush),
        .occupancy        (occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        dispatch_valid = 1'b0;
        wakeup_valid   = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic drive_disp(input logic urs, input logic [5:0] rsp, input logic rsr,
                              input logic urt, input logic [5:0] rtp, input logic rtr,
                              input logic [4:0] al);
        dispatch_valid   = 1'b1;
        dispatch_uses_rs = urs;
        dispatch_rs_preg = rsp;
        dispatch_rs_rdy  = rsr;
        dispatch_uses_rt = urt;
        dispatch_rt_preg = rtp;
        dispatch_rt_rdy  = rtr;
        dispatch_al_idx  = al;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (dispatch_ready !== 1'b0 || occupancy !== 6'd0 || issue_valid !== 1'b0 ||
            issue_slot !== 5'd0 || issue_al_idx !== 5'd0 || alloc_slot !== 5'd0) begin
            failures++;
            $display("FAIL reset_state: dr=%b occ=%0d iv=%b is=%0d ia=%0d as=%0d, want 0 0 0 0 0 0",
                     dispatch_ready, occupancy, issue_valid, issue_slot, issue_al_idx, alloc_slot);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (dispatch_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1", dispatch_ready);
        end
    endtask

    task automatic test_in_order();
        exp_t e;
        int   n = 0, first = -1, last = -1;
        issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_disp(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 5'(k));
            e.slot = 5'(k); e.al = 5'(k); sb.push_back(e);
            #1;
            checks++;
            if (alloc_slot !== 5'(k)) begin
                failures++;
                $display("FAIL inorder_alloc: got %0d want %0d", alloc_slot, k);
            end
            tick();
        end
        idle();
        issue_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (issue_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL inorder_issue: got slot %0d, want no issue", issue_slot);
                end else begin
                    e = sb.pop_front();
                    if (issue_slot !== e.slot || issue_al_idx !== e.al) begin
                        failures++;
                        $display("FAIL inorder_issue: got slot %0d al %0d want slot %0d al %0d",
                                 issue_slot, issue_al_idx, e.slot, e.al);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                n++;
            end
            tick();
        end
        checks++;
        if (n != 3 || last - first != 2) begin
            failures++;
            $display("FAIL inorder_rate: got %0d issues over span %0d want 3 over 2", n, last - first);
        end
        checks++;
        if (occupancy !== 6'd0) begin
            failures++;
            $display("FAIL inorder_occ: got %0d want 0", occupancy);
        end
    endtask

    task automatic test_wakeup_order();
        exp_t e;
        issue_ready = 1'b1;
        drive_disp(1'b1, 6'd10, 1'b0, 1'b0, 6'd0, 1'b0, 5'd5);
        #1;
        checks++;
        if (alloc_slot !== 5'd0) begin
            failures++;
            $display("FAIL wake_alloc_a: got %0d want 0", alloc_slot);
        end
        tick();
        drive_disp(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd6);
        e.slot = 5'd1; e.al = 5'd6; sb.push_back(e);
        e.slot = 5'd0; e.al = 5'd5; sb.push_back(e);
        #1;
        checks++;
        if (alloc_slot !== 5'd1 || issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL wake_b_dispatch: got alloc %0d iv %b want 1 0", alloc_slot, issue_valid);
        end
        tick();
        idle();
        wakeup_valid = 1'b1;
        wakeup_preg  = 6'd10;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            e = sb.pop_front();
            if (issue_valid !== 1'b1 || issue_slot !== e.slot || issue_al_idx !== e.al) begin
                failures++;
                $display("FAIL wake_issue%0d: got iv %b slot %0d al %0d want 1 slot %0d al %0d",
                         k, issue_valid, issue_slot, issue_al_idx, e.slot, e.al);
            end
            tick();
            idle();
        end
        #1;
        checks++;
        if (issue_valid !== 1'b0 || occupancy !== 6'd0) begin
            failures++;
            $display("FAIL wake_drain: got iv %b occ %0d want 0 0", issue_valid, occupancy);
        end
    endtask

    task automatic test_full();
        exp_t e;
        int   bad = 0;
        issue_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 7) begin
                drive_disp(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd7);
                e.slot = 5'd7; e.al = 5'd7; sb.push_back(e);
            end else begin
                drive_disp(1'b1, 6'd40, 1'b0, 1'b0, 6'd0, 1'b0, 5'(i));
            end
            #1;
            if (alloc_slot !== 5'(i) || dispatch_ready !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL full_fill: got %0d bad allocations want 0", bad);
        end
        idle();
        #1;
        checks++;
        if (dispatch_ready !== 1'b0 || occupancy !== 6'd32 || issue_valid !== 1'b1 || issue_slot !== 5'd7) begin
            failures++;
            $display("FAIL full_state: got dr %b occ %0d iv %b slot %0d want 0 32 1 7",
                     dispatch_ready, occupancy, issue_valid, issue_slot);
        end
        issue_ready = 1'b1;
        drive_disp(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd30);
        #1;
        checks++;
        e = sb.pop_front();
        if (dispatch_ready !== 1'b0 || issue_slot !== e.slot || issue_al_idx !== e.al) begin
            failures++;
            $display("FAIL full_issue: got dr %b slot %0d al %0d want 0 slot %0d al %0d",
                     dispatch_ready, issue_slot, issue_al_idx, e.slot, e.al);
        end
        tick();
        idle();
        issue_ready = 1'b0;
        #1;
        checks++;
        if (alloc_slot !== 5'd7 || dispatch_ready !== 1'b1 || occupancy !== 6'd31 || issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_refree: got alloc %0d dr %b occ %0d iv %b want 7 1 31 0",
                     alloc_slot, dispatch_ready, occupancy, issue_valid);
        end
        flush = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if (occupancy !== 6'd0) begin
            failures++;
            $display("FAIL full_flush_occ: got %0d want 0", occupancy);
        end
    endtask

    task automatic test_hold_older();
        exp_t e;
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) drive_disp(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd13);
            else        drive_disp(1'b1, 6'(30 + k), 1'b0, 1'b0, 6'd0, 1'b0, 5'(10 + k));
            #1;
            checks++;
            if (alloc_slot !== 5'(k)) begin
                failures++;
                $display("FAIL hold_alloc: got %0d want %0d", alloc_slot, k);
            end
            tick();
        end
        e.slot = 5'd3; e.al = 5'd13; sb.push_back(e);
        e.slot = 5'd1; e.al = 5'd11; sb.push_back(e);
        idle();
        wakeup_valid = 1'b1;
        wakeup_preg  = 6'd31;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (issue_valid !== 1'b1 || issue_slot !== 5'd3 || issue_al_idx !== 5'd13) begin
                failures++;
                $display("FAIL hold_pinned%0d: got iv %b slot %0d al %0d want 1 3 13",
                         k, issue_valid, issue_slot, issue_al_idx);
            end
            tick();
            idle();
        end
        issue_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            e = sb.pop_front();
            if (issue_valid !== 1'b1 || issue_slot !== e.slot || issue_al_idx !== e.al) begin
                failures++;
                $display("FAIL hold_release%0d: got iv %b slot %0d al %0d want 1 slot %0d al %0d",
                         k, issue_valid, issue_slot, issue_al_idx, e.slot, e.al);
            end
            tick();
        end
        #1;
        checks++;
        if (issue_valid !== 1'b0 || occupancy !== 6'd2) begin
            failures++;
            $display("FAIL hold_rest: got iv %b occ %0d want 0 2", issue_valid, occupancy);
        end
        flush = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        exp_t e;
        issue_ready = 1'b1;
        drive_disp(1'b0, 6'd0, 1'b0, 1'b1, 6'd20, 1'b0, 5'd21);
        wakeup_valid = 1'b1;
        wakeup_preg  = 6'd20;
        e.slot = 5'd0; e.al = 5'd21; sb.push_back(e);
        #1;
        checks++;
        if (alloc_slot !== 5'd0 || issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL bypass_dispatch: got alloc %0d iv %b want 0 0", alloc_slot, issue_valid);
        end
        tick();
        idle();
        #1;
        checks++;
        e = sb.pop_front();
        if (issue_valid !== 1'b1 || issue_slot !== e.slot || issue_al_idx !== e.al) begin
            failures++;
            $display("FAIL bypass_issue: got iv %b slot %0d al %0d want 1 slot %0d al %0d",
                     issue_valid, issue_slot, issue_al_idx, e.slot, e.al);
        end
        tick();
        #1;
        checks++;
        if (occupancy !== 6'd0) begin
            failures++;
            $display("FAIL bypass_occ: got %0d want 0", occupancy);
        end
    endtask

    task automatic test_flush();
        issue_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive_disp(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 5'(20 + k));
            tick();
        end
        idle();
        #1;
        checks++;
        if (issue_valid !== 1'b1 || occupancy !== 6'd10) begin
            failures++;
            $display("FAIL flush_pre: got iv %b occ %0d want 1 10", issue_valid, occupancy);
        end
        flush       = 1'b1;
        issue_ready = 1'b1;
        drive_disp(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd1);
        #1;
        checks++;
        if (issue_valid !== 1'b0 || dispatch_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle: got iv %b dr %b want 0 0", issue_valid, dispatch_ready);
        end
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (issue_valid !== 1'b0 || occupancy !== 6'd0) begin
                failures++;
                $display("FAIL flush_after%0d: got iv %b occ %0d want 0 0", k, issue_valid, occupancy);
            end
            tick();
        end
    endtask

    task automatic test_rst_mid();
        issue_ready = 1'b0;
        drive_disp(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd9);
        tick();
        idle();
        #1;
        checks++;
        if (issue_valid !== 1'b1 || issue_al_idx !== 5'd9) begin
            failures++;
            $display("FAIL rstmid_pre: got iv %b al %0d want 1 9", issue_valid, issue_al_idx);
        end
        issue_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (issue_valid !== 1'b0 || occupancy !== 6'd0 || dispatch_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_clear: got iv %b occ %0d dr %b want 0 0 0",
                     issue_valid, occupancy, dispatch_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (dispatch_ready !== 1'b1 || issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_after: got dr %b iv %b want 1 0", dispatch_ready, issue_valid);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_wakeup_order();
        test_full();
        test_hold_older();
        test_bypass();
        test_flush();
        test_rst_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iq_issue_scheduler.md
# iq_issue_scheduler

Control and select logic for the 32-entry instruction queue. Allocates a free queue slot for each dispatched instruction, tracks per-slot operand readiness from physical-register wakeup broadcasts, and selects the oldest fully-ready slot for issue over a valid/ready handshake to the execute stage. The block stores only slot state; the queue payload (ALU control, immediates, register addresses) stays in the queue storage, indexed by `alloc_slot` and `issue_slot`.

## Interface
- `IQ_DEPTH`, 32: number of queue slots; slot index width is `$clog2(IQ_DEPTH)`.
- `PREG_COUNT`, 64: number of physical registers; tag width is `$clog2(PREG_COUNT)`.
- `AL_IDX_W`, 5: active-list index width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `dispatch_valid`  in  1  dispatch stage offers an instruction.
- `dispatch_ready`  out  1  a slot is free; the instruction is accepted on `dispatch_valid & dispatch_ready` at the edge.
- `dispatch_uses_rs`, `dispatch_uses_rt`  in  1 each  operand is needed.
- `dispatch_rs_preg`, `dispatch_rt_preg`  in  6 each  physical source tags.
- `dispatch_rs_rdy`, `dispatch_rt_rdy`  in  1 each  busy-table readiness at dispatch.
- `dispatch_al_idx`  in  5  active-list index of the instruction.
- `alloc_slot`  out  5  slot the payload is written to this cycle; valid when `dispatch_ready` is high.
- `wakeup_valid`  in  1  a writeback broadcast this cycle.
- `wakeup_preg`  in  6  physical tag that became ready.
- `issue_valid`  out  1  a ready slot is presented.
- `issue_ready`  in  1  execute stage accepts the presented slot.
- `issue_slot`  out  5  selected slot.
- `issue_al_idx`  out  5  active-list index of the selected slot.
- `flush`  in  1  squash all entries.
- `occupancy`  out  6  count of valid slots, 0..32.

## Operation
- Per-slot state: `valid`, `rs_rdy`, `rt_rdy`, `rs_preg`, `rt_preg`, `al_idx`, and age-matrix row. An unused operand is written as ready.
- Allocation: `alloc_slot` is the lowest-index invalid slot. `dispatch_ready = (occupancy != IQ_DEPTH) & ~flush`.
- Dispatch write: the slot becomes valid and records tags and readiness. If a wakeup in the same cycle matches a dispatched tag, that operand is written as ready (bypass).
- Wakeup: every valid slot whose `rs_preg`/`rt_preg` equals `wakeup_preg` sets the matching ready bit at the edge.
- Select: among slots with `valid & rs_rdy & rt_rdy`, pick the oldest by age matrix. `older[i][j]` is set for all valid `j` when `i` is allocated, and cleared column-wise when `j` frees.
- Hold: when `issue_valid & ~issue_ready`, a lock register pins `issue_slot` and `issue_al_idx` until accepted or flushed, even if an older slot wakes.
- Issue accept: on `issue_valid & issue_ready`, the slot goes invalid at the edge and the lock clears.
- Flush: at the edge, all slots go invalid and the lock clears. During the flush cycle `issue_valid` is 0 and dispatch is not accepted.
- Occupancy: +1 on accepted dispatch, -1 on issue accept, net 0 when both occur; reset to 0 on flush.

## Timing
- Reset: all slots invalid; `occupancy` 0; `issue_valid` 0; `issue_slot`, `issue_al_idx`, and `alloc_slot` 0; `dispatch_ready` 0 while `rst` is high and 1 the first cycle after.
- Dispatch-to-issue: a slot dispatched fully ready at edge N can be presented in cycle N+1. There is no same-cycle dispatch-to-issue.
- Wakeup-to-issue: a wakeup at edge N makes the slot selectable in cycle N+1.
- Full: when occupancy is 32, `dispatch_ready` is 0. A slot freed by issue at edge N is allocatable in cycle N+1, not in the same cycle.
- Simultaneous dispatch and issue of different slots are both honoured.
- `rst` asserted mid-handshake: state clears immediately; no issue is reported.

## Structure
- Shared package (`mips_core_pkg`): `IQ_DEPTH`, `PREG_COUNT`, typedefs `IqSlot` (5-bit) and `PhysReg` (6-bit).
- Sub-module `iq_age_matrix`: holds the N×N older bits, takes alloc/free/flush inputs, and outputs a one-hot oldest selection over a request vector.
- Priority encoder for allocation stays inline.

## Test plan
- Reset, then dispatch 3 fully-ready instructions with al_idx 0, 1, 2 -> issue order is slots 0, 1, 2 and al_idx 0, 1, 2, one per cycle with `issue_ready` held 1; occupancy ends at 0.
- Dispatch A (rs=p10, not ready), then B (ready) -> B issues first; wakeup p10 at edge N -> A is presented in cycle N+1.
- Fill 32 slots -> `dispatch_ready` is 0 and occupancy is 32; issue one (slot 7) -> next cycle `alloc_slot` is 7 and `dispatch_ready` is 1.
- Hold `issue_ready` at 0 with slot 3 presented, then wake an older slot 1 -> `issue_slot` stays 3 until accepted, then slot 1 is presented.
- Dispatch with rs=p20 in the same cycle as a wakeup of p20 -> the slot issues the next cycle.
- 10 valid entries, assert `flush` with `issue_valid` high -> `issue_valid` drops that cycle, occupancy is 0 next cycle, and no stale issue follows.
